// File: rtl/alu_arith_seq_if.sv
// alu_arith_seq_if: request/response handshake and external ALU connection bundle.
interface alu_arith_seq_if #(parameter int CNT_W = 16);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [31:0]      alu_in1;
  logic [31:0]      alu_in2;
  logic             alu_sel0;
  logic             alu_sel1;
  logic             alu_sel2;
  logic             alu_sel3;
  logic             alu_sel4;
  logic [31:0]      alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic [CNT_W-1:0] op_count;
  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_out, rsp_ready,
    output req_ready, alu_in1, alu_in2, alu_sel0, alu_sel1, alu_sel2, alu_sel3, alu_sel4,
           rsp_valid, rsp_data, rsp_err, op_count
  );
  modport master (
    output req_valid, req_op, req_a, req_b, alu_out, rsp_ready,
    input  req_ready, alu_in1, alu_in2, alu_sel0, alu_sel1, alu_sel2, alu_sel3, alu_sel4,
           rsp_valid, rsp_data, rsp_err, op_count
  );
endinterface

// File: rtl/alu_arith_seq.sv
// alu_arith_seq: sequences one arithmetic/compare request through an external combinational ALU.
module alu_arith_seq #(
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  alu_arith_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  // Select codes, leftmost bit is sel0.
  localparam logic [4:0] SEL_TAB [8] = '{5'b00000, 5'b00011, 5'b00001, 5'b10001,
                                         5'b01001, 5'b11001, 5'b00101, 5'b01101};
  state_t state;
  logic   accept;
  assign accept = bus.req_valid && bus.req_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_data  <= '0;
      bus.alu_in1   <= '0;
      bus.alu_in2   <= '0;
      {bus.alu_sel0, bus.alu_sel1, bus.alu_sel2, bus.alu_sel3, bus.alu_sel4} <= '0;
      bus.op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.req_ready <= !accept;
          if (accept && !bus.req_op[3]) begin
            bus.alu_in1 <= bus.req_a;
            bus.alu_in2 <= bus.req_b;
            {bus.alu_sel0, bus.alu_sel1, bus.alu_sel2, bus.alu_sel3, bus.alu_sel4} <= SEL_TAB[bus.req_op[2:0]];
            state <= EXEC;
          end else if (accept) begin
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end
        end
        EXEC: begin
          bus.rsp_data  <= bus.alu_out;
          bus.rsp_err   <= 1'b0;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.op_count  <= bus.op_count + CNT_W'(1);
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arith_seq.sv
// tb_alu_arith_seq: randomized and directed checks of alu_arith_seq against an opcode-level model.
module tb_alu_arith_seq;
  localparam int CNT_W = 4;
  logic clk = 0;
  logic rst_n = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  logic [31:0] last_a = 0, last_b = 0;
  logic [4:0]  last_sel = 0;
  logic [4:0]  sel_tab [8] = '{5'b00000, 5'b00011, 5'b00001, 5'b10001,
                               5'b01001, 5'b11001, 5'b00101, 5'b01101};
  always #5 clk = ~clk;
  alu_arith_seq_if #(.CNT_W(CNT_W)) bus ();
  alu_arith_seq #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return {31'd0, a == b};
      4'd3: return {31'd0, a != b};
      4'd4: return {31'd0, $signed(a) <  $signed(b)};
      4'd5: return {31'd0, $signed(a) >  $signed(b)};
      4'd6: return {31'd0, $signed(a) <= $signed(b)};
      4'd7: return {31'd0, $signed(a) >= $signed(b)};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] sel_to_op(input logic [4:0] s);
    for (int i = 0; i < 8; i++) if (sel_tab[i] == s) return 4'(i);
    return 4'd15;
  endfunction

  logic [4:0] sels;
  assign sels = {bus.alu_sel0, bus.alu_sel1, bus.alu_sel2, bus.alu_sel3, bus.alu_sel4};
  assign bus.alu_out = model(sel_to_op(sels), bus.alu_in1, bus.alu_in2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.rsp_valid), 0);
    check({tag, "_data"}, bus.rsp_data, 0);
    check({tag, "_err"}, 32'(bus.rsp_err), 0);
    check({tag, "_in1"}, bus.alu_in1, 0);
    check({tag, "_in2"}, bus.alu_in2, 0);
    check({tag, "_sel"}, 32'(sels), 0);
    check({tag, "_cnt"}, 32'(bus.op_count), 0);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    int n = 0;
    logic [31:0] exp_d;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    check("req_ready_wait", 32'(bus.req_ready), 1);
    bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_valid = 1;
    @(negedge clk);
    bus.req_op = 4'($urandom); bus.req_a = $urandom; bus.req_b = $urandom;
    bus.req_valid = 1'($urandom);
    exp_d = model(op, a, b);
    if (!op[3]) begin
      last_a = a; last_b = b; last_sel = sel_tab[op[2:0]];
      check("exec_valid", 32'(bus.rsp_valid), 0);
      check("exec_ready", 32'(bus.req_ready), 0);
      check("alu_in1", bus.alu_in1, a);
      check("alu_in2", bus.alu_in2, b);
      check("sels", 32'(sels), 32'(last_sel));
      @(negedge clk);
    end
    check("rsp_valid", 32'(bus.rsp_valid), 1);
    check("rsp_data", bus.rsp_data, exp_d);
    check("rsp_err", 32'(bus.rsp_err), 32'(op[3]));
    check("held_in1", bus.alu_in1, last_a);
    check("held_in2", bus.alu_in2, last_b);
    check("held_sels", 32'(sels), 32'(last_sel));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.req_valid = 1;
      check("hold_valid", 32'(bus.rsp_valid), 1);
      check("hold_data", bus.rsp_data, exp_d);
      check("hold_err", 32'(bus.rsp_err), 32'(op[3]));
      check("hold_ready", 32'(bus.req_ready), 0);
    end
    bus.req_valid = 0;
    bus.rsp_ready = 1;
    @(negedge clk);
    bus.rsp_ready = 0;
    exp_cnt++;
    check("done_valid", 32'(bus.rsp_valid), 0);
    check("done_ready", 32'(bus.req_ready), 1);
    check("op_count", 32'(bus.op_count), 32'(exp_cnt % (1 << CNT_W)));
  endtask

  initial begin
    bus.req_valid = 0; bus.req_op = 0; bus.req_a = 0; bus.req_b = 0; bus.rsp_ready = 0;
    #12;
    check_idle_outputs("reset");
    check("reset_ready", 32'(bus.req_ready), 0);
    @(negedge clk); rst_n = 1;
    check("ready_before_edge", 32'(bus.req_ready), 0);
    @(negedge clk);
    check("ready_after_edge", 32'(bus.req_ready), 1);
    do_op(4'd0, 32'h5, 32'h3, 0);
    do_op(4'd1, 32'h3, 32'h5, 1);
    do_op(4'd4, 32'h3, 32'h5, 0);
    do_op(4'hC, 32'h1234, 32'h9, 2);
    do_op(4'd2, 32'h7, 32'h7, 5);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 1) == 1) begin a = a >> $urandom_range(0, 31); b = b >> $urandom_range(0, 31); end
      do_op(($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7)), a, b, $urandom_range(0, 3));
    end
    // Abort mid-EXEC with an asynchronous reset pulse between clock edges.
    bus.req_op = 4'd0; bus.req_a = 32'h11; bus.req_b = 32'h22; bus.req_valid = 1;
    @(negedge clk);
    bus.req_valid = 0;
    check("abort_in_exec", bus.alu_in1, 32'h11);
    #2 rst_n = 0;
    #1 check_idle_outputs("abort");
    check("abort_ready", 32'(bus.req_ready), 0);
    #1 rst_n = 1;
    exp_cnt = 0; last_a = 0; last_b = 0; last_sel = 0;
    @(negedge clk);
    check("abort_ready_next", 32'(bus.req_ready), 1);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_rsp", 32'(bus.rsp_valid), 0);
      @(negedge clk);
    end
    for (int i = 0; i < 17; i++) do_op(4'($urandom_range(0, 15)), $urandom, $urandom, 0);
    check("wrap_count", 32'(bus.op_count), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_arith_seq.md
ALU_ARITH_SEQ -- requirements
Module: alu_arith_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the completed-operation counter.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1: request present.
REQ-005 SHALL have port req_ready  output  1: block can accept a request.
REQ-006 SHALL have port req_op  input  4: opcode; 0 ADD, 1 SUB, 2 SEQ, 3 SNE, 4 SLT, 5 SGT, 6 SLE, 7 SGE, 8-15 illegal.
REQ-007 SHALL have ports req_a, req_b  input  32: operands.
REQ-008 SHALL have ports alu_in1, alu_in2  output  32: operands driven to the combinational arithmetic ALU.
REQ-009 SHALL have ports alu_sel0..alu_sel4  output  1 each: ALU control selects.
REQ-010 SHALL have port alu_out  input  32: combinational ALU result.
REQ-011 SHALL have port rsp_valid  output  1: response present.
REQ-012 SHALL have port rsp_ready  input  1: consumer accepts response.
REQ-013 SHALL have port rsp_data  output  32: captured result.
REQ-014 SHALL have port rsp_err  output  1: response belongs to an illegal opcode.
REQ-015 SHALL have port op_count  output  CNT_W: count of completed responses.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-017 SHALL assert req_ready only in IDLE; request accepted on edge where req_valid and req_ready are both 1.
REQ-018 On accept of legal opcode SHALL register req_a->alu_in1, req_b->alu_in2, decoded selects, and go to EXEC.
REQ-019 Select decode (sel0..sel4) SHALL be: ADD 00000, SUB 00011, SEQ 00001, SNE 10001, SLT 01001, SGT 11001, SLE 00101, SGE 01101 (don't-care bits driven 0).
REQ-020 In EXEC (exactly one cycle) SHALL capture alu_out into rsp_data, clear rsp_err, and go to RESP.
REQ-021 On accept of illegal opcode SHALL leave alu_in1/alu_in2/selects unchanged, set rsp_data=0, rsp_err=1, and go directly to RESP.
REQ-022 In RESP SHALL hold rsp_valid=1 and rsp_data/rsp_err stable until rsp_ready=1; on that edge go to IDLE and drop rsp_valid.
REQ-023 Latency: legal op accepted at edge N -> rsp_valid=1 from edge N+2; illegal op -> from edge N+1.
REQ-024 rsp_valid SHALL be 0 in IDLE and EXEC; req_valid in EXEC/RESP SHALL be ignored (no queuing).
REQ-025 op_count SHALL increment by 1 on each response handshake (legal or illegal), wrapping 2^CNT_W-1 -> 0.
REQ-026 alu_in1/alu_in2/selects SHALL change only on legal accept; held otherwise.

Reset
REQ-027 rst_n=0 SHALL immediately, independent of clk, force state IDLE, rsp_valid=0, rsp_err=0, rsp_data=0, alu_in1=alu_in2=0, all selects 0, op_count=0.
REQ-028 req_ready SHALL be 0 while rst_n=0 and 1 from first clk edge after rst_n rises.
REQ-029 Reset asserted in EXEC or RESP SHALL abort the operation; no response is produced for it.

Verification
REQ-030 ADD 0x00000005+0x00000003 -> sels 00000, rsp_data=0x00000008, rsp_err=0, rsp_valid at accept+2.
REQ-031 SUB 0x00000003-0x00000005 -> sels 00011, rsp_data=0xFFFFFFFE; SLT 3,5 -> sels 01001, rsp_data=1.
REQ-032 req_op=0xC, req_a=0x1234 -> rsp_valid at accept+1, rsp_data=0, rsp_err=1, alu_in1 unchanged.
REQ-033 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, req_ready=0, second req_valid ignored.
REQ-034 CNT_W=4, 17 completed ops -> op_count=1 (wrap).
REQ-035 rst_n pulsed low mid-EXEC -> rsp_valid never asserts, all outputs 0, op_count=0, req_ready=1 next edge.
